// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: FSM state codes, game key codes
// and the small column/row encoding helpers used by the scanner.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        KS_SCAN = 2'd0,
        KS_DEB  = 2'd1,
        KS_HELD = 2'd2
    } ks_state_e;

    // Key codes are {row[1:0], col[1:0]} as seen by game control.
    localparam logic [3:0] KEY_JUMP  = 4'h1;
    localparam logic [3:0] KEY_DUCK  = 4'h5;
    localparam logic [3:0] KEY_START = 4'hF;

    localparam logic [3:0] COL_IDLE  = 4'hF;

    // Lowest-numbered active-low column wins when several are pulled down.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        if (col[0] == 1'b0) begin
            idx = 2'd0;
        end else if (col[1] == 1'b0) begin
            idx = 2'd1;
        end else if (col[2] == 1'b0) begin
            idx = 2'd2;
        end else if (col[3] == 1'b0) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running scan-rate divider: one-cycle tick every SCAN_DIV clk2 cycles,
// first tick SCAN_DIV cycles after reset is released. Shared with display scanners.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk2,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(SCAN_DIV - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider count; tick is registered one count early so it is high exactly while cnt is at its last value.
    always_ff @(posedge clk2) begin
        if (reset) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + CNT_ONE;
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: walks active-low rows, debounces press and release on
// scan ticks, and reports one key_valid pulse per accepted press.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_TICKS = 4
) (
    input  logic       clk2,
    input  logic       reset,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_TICKS);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);
    localparam logic [DW-1:0] DEB_ZERO = {DW{1'b0}};

    logic            tick_s;
    logic [3:0]      col_meta_r;
    logic [3:0]      col_s_r;

    ks_state_e       state_r,     state_next_s;
    logic [1:0]      row_idx_r,   row_idx_next_s;
    logic [3:0]      key_row_r,   key_row_next_s;
    logic [3:0]      cand_r,      cand_next_s;
    logic [DW-1:0]   deb_cnt_r,   deb_cnt_next_s;
    logic [DW-1:0]   rel_cnt_r,   rel_cnt_next_s;
    logic [3:0]      key_code_r,  key_code_next_s;
    logic            key_valid_r, key_valid_next_s;
    logic            key_down_r,  key_down_next_s;

    logic            col_hit_s;
    logic [1:0]      col_idx_s;
    logic [1:0]      row_adv_s;
    logic [DW-1:0]   deb_inc_s;
    logic [DW-1:0]   rel_inc_s;
    logic            accept_s;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk2  (clk2),
        .reset (reset),
        .tick  (tick_s)
    );

    // Two-flop synchroniser for the asynchronous column lines; idle level is all ones.
    always_ff @(posedge clk2) begin
        if (reset) begin
            col_meta_r <= COL_IDLE;
            col_s_r    <= COL_IDLE;
        end else begin
            col_meta_r <= key_col;
            col_s_r    <= col_meta_r;
        end
    end

    assign col_hit_s = (col_s_r != COL_IDLE);
    assign col_idx_s = col_index(col_s_r);
    assign row_adv_s = row_idx_r + 2'd1;
    assign deb_inc_s = (deb_cnt_r == DEB_MAX) ? DEB_MAX : deb_cnt_r + DEB_ONE;
    assign rel_inc_s = (rel_cnt_r == DEB_MAX) ? DEB_MAX : rel_cnt_r + DEB_ONE;

    // Next-state and output decisions; nothing moves except on scan ticks.
    always_comb begin
        state_next_s     = state_r;
        row_idx_next_s   = row_idx_r;
        key_row_next_s   = key_row_r;
        cand_next_s      = cand_r;
        deb_cnt_next_s   = deb_cnt_r;
        rel_cnt_next_s   = rel_cnt_r;
        key_code_next_s  = key_code_r;
        key_valid_next_s = 1'b0;
        key_down_next_s  = key_down_r;
        accept_s         = 1'b0;

        if (tick_s) begin
            case (state_r)
                KS_SCAN: begin
                    if (col_hit_s) begin
                        cand_next_s    = {row_idx_r, col_idx_s};
                        deb_cnt_next_s = DEB_ONE;
                        if (DEB_ONE == DEB_MAX) begin
                            accept_s = 1'b1;
                        end else begin
                            state_next_s = KS_DEB;
                        end
                    end else begin
                        row_idx_next_s = row_adv_s;
                        key_row_next_s = row_drive(row_adv_s);
                    end
                end
                KS_DEB: begin
                    if (col_hit_s && (col_idx_s == cand_r[1:0])) begin
                        deb_cnt_next_s = deb_inc_s;
                        if (deb_inc_s == DEB_MAX) begin
                            accept_s = 1'b1;
                        end else begin
                            state_next_s = KS_DEB;
                        end
                    end else begin
                        deb_cnt_next_s = DEB_ZERO;
                        row_idx_next_s = row_adv_s;
                        key_row_next_s = row_drive(row_adv_s);
                        state_next_s   = KS_SCAN;
                    end
                end
                KS_HELD: begin
                    // Any column on the held row counts as still pressed.
                    if (!col_hit_s) begin
                        rel_cnt_next_s = rel_inc_s;
                        if (rel_inc_s == DEB_MAX) begin
                            rel_cnt_next_s  = DEB_ZERO;
                            key_down_next_s = 1'b0;
                            row_idx_next_s  = row_adv_s;
                            key_row_next_s  = row_drive(row_adv_s);
                            state_next_s    = KS_SCAN;
                        end else begin
                            state_next_s = KS_HELD;
                        end
                    end else begin
                        rel_cnt_next_s = DEB_ZERO;
                    end
                end
                default: begin
                    deb_cnt_next_s = DEB_ZERO;
                    rel_cnt_next_s = DEB_ZERO;
                    state_next_s   = KS_SCAN;
                end
            endcase

            if (accept_s) begin
                key_code_next_s  = cand_next_s;
                key_valid_next_s = 1'b1;
                key_down_next_s  = 1'b1;
                deb_cnt_next_s   = DEB_ZERO;
                rel_cnt_next_s   = DEB_ZERO;
                state_next_s     = KS_HELD;
            end else begin
                key_valid_next_s = 1'b0;
            end
        end else begin
            key_valid_next_s = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk2) begin
        if (reset) begin
            state_r     <= KS_SCAN;
            row_idx_r   <= 2'd0;
            key_row_r   <= 4'b1110;
            cand_r      <= 4'h0;
            deb_cnt_r   <= DEB_ZERO;
            rel_cnt_r   <= DEB_ZERO;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            row_idx_r   <= row_idx_next_s;
            key_row_r   <= key_row_next_s;
            cand_r      <= cand_next_s;
            deb_cnt_r   <= deb_cnt_next_s;
            rel_cnt_r   <= rel_cnt_next_s;
            key_code_r  <= key_code_next_s;
            key_valid_r <= key_valid_next_s;
            key_down_r  <= key_down_next_s;
        end
    end

    assign key_row   = key_row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_down  = key_down_r;

endmodule
